// File: rtl/dance_judge_pkg.sv
// rtl/dance_judge_pkg.sv - shared lane-judge types and defaults
package dance_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    localparam int DEFAULT_WINDOW = 8;
    localparam int DEFAULT_TW     = 4;

endpackage

// File: rtl/dance_judge_if.sv
// rtl/dance_judge_if.sv - lane bus between scroller/player and the judge
interface dance_judge_if #(
    parameter int TW = 4
);
    logic          ARROW;
    logic          KEY;
    logic          UP;
    logic          DOWN;
    logic          HIT_ZONE;
    logic [TW-1:0] COMBO;

    modport master (
        output ARROW, KEY,
        input  UP, DOWN, HIT_ZONE, COMBO
    );

    modport slave (
        input  ARROW, KEY,
        output UP, DOWN, HIT_ZONE, COMBO
    );
endinterface

// File: rtl/dance_judge_key_edge.sv
// rtl/dance_judge_key_edge.sv - key synchroniser and rising-edge press detect
module key_edge (
    input  logic CLOCK,
    input  logic RESET,
    input  logic KEY,
    output logic PRESS
);
    logic k1, k2, k3;

    // Flops reset high so a key held across reset release never looks like a press.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            k1 <= 1'b1;
            k2 <= 1'b1;
            k3 <= 1'b1;
        end else begin
            k1 <= KEY;
            k2 <= k1;
            k3 <= k2;
        end
    end

    assign PRESS = k2 & ~k3;
endmodule

// File: rtl/dance_judge.sv
// rtl/dance_judge.sv - per-lane timing judge: hit/miss pulses and combo count
module dance_judge
    import dance_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int TW     = DEFAULT_TW
) (
    input  logic          CLOCK,
    input  logic          RESET,
    dance_judge_if.slave  bus
);
    localparam logic [TW-1:0] RELOAD = TW'(WINDOW - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [TW-1:0] combo, combo_n;
    logic          up, up_n;
    logic          down, down_n;
    logic          hit_zone;
    logic          press;

    key_edge u_key_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .KEY   (bus.KEY),
        .PRESS (press)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            timer    <= '0;
            combo    <= '0;
            up       <= 1'b0;
            down     <= 1'b0;
            hit_zone <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            combo    <= combo_n;
            up       <= up_n;
            down     <= down_n;
            hit_zone <= (state_n == OPEN);
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        up_n    = 1'b0;
        down_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ARROW && !press) begin
                    state_n = OPEN;
                    timer_n = RELOAD;
                end else if (press) begin
                    // With an arrow this is an instant hit, without one a stray press.
                    up_n   = bus.ARROW;
                    down_n = !bus.ARROW;
                end
            end
            OPEN: begin
                if (press) begin
                    up_n = 1'b1;
                    if (bus.ARROW) timer_n = RELOAD;
                    else           state_n = IDLE;
                end else if (bus.ARROW) begin
                    down_n  = 1'b1;
                    timer_n = RELOAD;
                end else if (timer == '0) begin
                    down_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A hit always wins over a clear; saturate at all-ones.
    always_comb begin
        combo_n = combo;
        if (up_n) begin
            if (combo != '1) combo_n = combo + 1'b1;
        end else if (down_n) begin
            combo_n = '0;
        end
    end

    assign bus.UP       = up;
    assign bus.DOWN     = down;
    assign bus.HIT_ZONE = hit_zone;
    assign bus.COMBO    = combo;
endmodule
